// File: rtl/line_burst_pkg.sv
// Shared types and constants for the cache-line to memory-burst adapter.
package line_burst_pkg;

    localparam int unsigned LINE_WIDTH_C  = 256;
    localparam int unsigned BURST_WIDTH_C = 64;
    localparam int unsigned ADDR_WIDTH_C  = 32;
    localparam int unsigned BEATS_C       = LINE_WIDTH_C / BURST_WIDTH_C;
    localparam int unsigned OFFSET_BITS_C = $clog2(LINE_WIDTH_C / 8);
    localparam int unsigned STAT_WIDTH_C  = 32;
    localparam int unsigned STATE_WIDTH_C = 3;

    localparam logic [STATE_WIDTH_C-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_WIDTH_C-1:0] ST_READ  = 3'd1;
    localparam logic [STATE_WIDTH_C-1:0] ST_WRITE = 3'd2;
    localparam logic [STATE_WIDTH_C-1:0] ST_DONE  = 3'd3;
    localparam logic [STATE_WIDTH_C-1:0] ST_GUARD = 3'd4;

    typedef enum logic [STATE_WIDTH_C-1:0] {
        LBA_IDLE  = ST_IDLE,
        LBA_READ  = ST_READ,
        LBA_WRITE = ST_WRITE,
        LBA_DONE  = ST_DONE,
        LBA_GUARD = ST_GUARD
    } lba_state_t;

    typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index shared by the fill and writeback bursts; wraps 3 -> 0.
module burst_beat_counter
    import line_burst_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      inc,
    output beat_idx_t count_o,
    output logic      last_c
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_o <= '0;
        end else if (inc) begin
            count_o <= beat_idx_t'(count_o + 2'd1);
        end
    end

    assign last_c = (count_o == beat_idx_t'(BEATS_C - 1));

endmodule

// File: rtl/line_burst_adapter.sv
// Splits a 256-bit line fill/writeback into a 4-beat 64-bit memory burst.
// Optional LINE_BURST_ADAPTER_STATS_EN adds fill/writeback/stall counters.
module line_burst_adapter
    import line_burst_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = LINE_WIDTH_C,
    parameter int unsigned BURST_WIDTH = BURST_WIDTH_C,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_C
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
`ifdef LINE_BURST_ADAPTER_STATS_EN
    ,
    output logic [STAT_WIDTH_C-1:0] fill_count_o,
    output logic [STAT_WIDTH_C-1:0] wb_count_o,
    output logic [STAT_WIDTH_C-1:0] stall_count_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    lba_state_t             state_q, state_d;
    logic [LINE_WIDTH-1:0]  buf_q, buf_d;
    logic [LINE_WIDTH-1:0]  line_d;
    logic [BURST_WIDTH-1:0] burst_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   read_d, write_d, resp_d;
    logic                   cnt_clr, cnt_inc, cnt_last;
    beat_idx_t              cnt;

    burst_beat_counter u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .inc    (cnt_inc),
        .count_o(cnt),
        .last_c (cnt_last)
    );

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        line_d  = line_o;
        burst_d = burst_o;
        addr_d  = address_o;
        read_d  = 1'b0;
        write_d = 1'b0;
        resp_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            LBA_IDLE: begin
                cnt_clr = 1'b1;
                if (write_i) begin
                    buf_d   = line_i;
                    burst_d = line_i[BURST_WIDTH-1:0];
                    addr_d  = address_i & ADDR_MASK;
                    write_d = 1'b1;
                    state_d = LBA_WRITE;
                end else if (read_i) begin
                    addr_d  = address_i & ADDR_MASK;
                    read_d  = 1'b1;
                    state_d = LBA_READ;
                end
            end
            LBA_READ: begin
                read_d = 1'b1;
                if (resp_i) begin
                    cnt_inc = 1'b1;
                    buf_d[BURST_WIDTH * 32'(cnt) +: BURST_WIDTH] = burst_i;
                    if (cnt_last) begin
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        line_d  = buf_d;
                        state_d = LBA_DONE;
                    end
                end
            end
            LBA_WRITE: begin
                write_d = 1'b1;
                if (resp_i) begin
                    cnt_inc = 1'b1;
                    buf_d   = buf_q >> BURST_WIDTH;
                    burst_d = buf_q[2*BURST_WIDTH-1:BURST_WIDTH];
                    if (cnt_last) begin
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                        state_d = LBA_DONE;
                    end
                end
            end
            // GUARD absorbs the controller's still-registered request.
            LBA_DONE:  state_d = LBA_GUARD;
            LBA_GUARD: state_d = LBA_IDLE;
            default:   state_d = LBA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LBA_IDLE;
            buf_q     <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            line_o    <= line_d;
            burst_o   <= burst_d;
            address_o <= addr_d;
            read_o    <= read_d;
            write_o   <= write_d;
            resp_o    <= resp_d;
        end
    end

`ifdef LINE_BURST_ADAPTER_STATS_EN
    logic fill_q;

    // Saturating transaction and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q        <= 1'b0;
            fill_count_o  <= '0;
            wb_count_o    <= '0;
            stall_count_o <= '0;
        end else begin
            if (state_q == LBA_IDLE && (write_i || read_i)) begin
                fill_q <= !write_i;
            end
            if (state_q == LBA_DONE) begin
                if (fill_q && fill_count_o != '1) begin
                    fill_count_o <= fill_count_o + 1'b1;
                end
                if (!fill_q && wb_count_o != '1) begin
                    wb_count_o <= wb_count_o + 1'b1;
                end
            end
            if ((state_q == LBA_READ || state_q == LBA_WRITE) && !resp_i
                && stall_count_o != '1) begin
                stall_count_o <= stall_count_o + 1'b1;
            end
        end
    end
`endif

endmodule
